// File: rtl/vesp_boot_loader.sv
// Boot/program-load engine for vesp1_risc: clears memory, loads a program from a
// valid/ready {address, data} stream, then releases the CPU from reset.
module vesp_boot_loader #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDRESS_SIZE = 12,
    parameter int DEPTH        = 256,
    parameter bit FLUSH_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [ADDRESS_SIZE-1:0] load_addr,
    input  logic [WORD_SIZE-1:0]    load_data,
    input  logic                    load_last,
    input  logic                    reboot,
    output logic                    mem_we,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    output logic                    cpu_rst_n,
    output logic                    busy,
    output logic                    err,
    output logic [ADDRESS_SIZE:0]   words_loaded
);

    // state | meaning
    // FLUSH | write zero to addresses 0..DEPTH-1, one per cycle
    // LOAD  | accept stream words, write in-range ones straight through
    // RUN   | CPU released; wait for a reboot request

    typedef enum logic [1:0] {FLUSH, LOAD, RUN} state_t;

    localparam state_t                  START     = FLUSH_EN ? FLUSH : LOAD;
    localparam int                      CW        = ADDRESS_SIZE + 1;
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(DEPTH - 1);
    localparam logic [CW-1:0]           DEPTH_W   = CW'(DEPTH);

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [CW-1:0]           wl_q, wl_d;
    logic                    cpu_q;
    logic                    in_range;

    // compare one bit wider so DEPTH == 2**ADDRESS_SIZE never overflows
    assign in_range = {1'b0, load_addr} < DEPTH_W;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        wl_d       = wl_q;
        load_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            FLUSH: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    if (in_range) begin
                        mem_we    = 1'b1;
                        mem_addr  = load_addr;
                        mem_wdata = load_data;
                        if (wl_q != '1) wl_d = wl_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (load_last) state_d = RUN;
                end
            end
            RUN: begin
                if (reboot) begin
                    state_d = START;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    wl_d    = '0;
                end
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= START;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wl_q    <= '0;
            cpu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wl_q    <= wl_d;
            cpu_q   <= (state_d == RUN);
        end
    end

    assign cpu_rst_n    = cpu_q;
    assign busy         = (state_q != RUN);
    assign err          = err_q;
    assign words_loaded = wl_q;

endmodule

// File: doc/vesp_boot_loader.md
Name: vesp_boot_loader

Overview:
Synthesizable boot/program-load engine for the vesp1_risc core. It owns the main memory write port and holds the CPU in reset. After reset it clears a parametrised address range, then loads a program from a valid/ready stream of {address, data} words. It releases the CPU once the last word is accepted, and can re-run the full sequence on request.

Parameters:
- WORD_SIZE, 16, memory data width in bits.
- ADDRESS_SIZE, 12, memory address width in bits.
- DEPTH, 256, number of words cleared and legal load range; addresses 0..DEPTH-1; DEPTH <= 2**ADDRESS_SIZE.
- FLUSH_EN, 1, 1 = clear memory before load; 0 = skip FLUSH and enter LOAD directly.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  stream word present.
- load_ready  output  1  loader accepts a stream word this cycle.
- load_addr  input  ADDRESS_SIZE  target address of the stream word.
- load_data  input  WORD_SIZE  data of the stream word.
- load_last  input  1  marks the final stream word.
- reboot  input  1  single-cycle request to re-run flush and load.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDRESS_SIZE  memory write address.
- mem_wdata  output  WORD_SIZE  memory write data.
- cpu_rst_n  output  1  active-low reset to the CPU core.
- busy  output  1  high whenever state != RUN.
- err  output  1  sticky flag: an out-of-range load address was received.
- words_loaded  output  ADDRESS_SIZE+1  count of words written during LOAD; saturates at all-ones.

Behaviour:
- Reset (rst=0, async):
  - State goes to FLUSH if FLUSH_EN=1, otherwise LOAD.
  - Flush counter = 0, cpu_rst_n=0, err=0, words_loaded=0, busy=1.
- States: FLUSH, LOAD, RUN.
- FLUSH:
  - mem_we=1, mem_addr=counter, mem_wdata=0. load_ready=0.
  - The counter increments each cycle. Exactly DEPTH write cycles, addresses 0..DEPTH-1 in order.
  - After the cycle with addr=DEPTH-1: the counter resets to 0 and the next state is LOAD.
- LOAD:
  - load_ready=1. A word is accepted on a cycle where load_valid & load_ready are both high.
  - Accepted word with load_addr < DEPTH: mem_we=1 in the same cycle, combinationally driven from the inputs (mem_addr=load_addr, mem_wdata=load_data). words_loaded increments at the edge.
  - Accepted word with load_addr >= DEPTH: mem_we=0, err set, word consumed, words_loaded unchanged.
  - Accepted word with load_last=1: next state is RUN. This word is written like any other if it is in range.
  - load_valid=0 leaves the state unchanged; no timeout.
  - Repeated addresses are allowed; the last write wins.
- RUN:
  - cpu_rst_n=1 (registered, high from the first RUN cycle, i.e. one cycle after the last word is accepted).
  - load_ready=0, mem_we=0, busy=0.
  - reboot=1 moves to FLUSH (or LOAD if FLUSH_EN=0) at the next edge, with cpu_rst_n=0 from that edge.
  - Reboot clears words_loaded and err.
- reboot is ignored in FLUSH and LOAD.
- When mem_we=0: mem_addr and mem_wdata are driven 0.
- rst asserted mid-FLUSH or mid-LOAD: immediate return to the reset values and the sequence restarts from its beginning. Partial writes are not undone.
- Simultaneous events:
  - load_last accepted together with reboot in LOAD: reboot is ignored; the next state is RUN.
  - load_valid with load_ready=0: no effect; the stream source must hold the word.
- Parameter rules: DEPTH=1 gives one flush cycle. DEPTH=2**ADDRESS_SIZE makes err unreachable.

Test Plan:
- Use the default parameters throughout.
- Flush: preload memory with 16'hFFFF, release rst, drive no stream.
  - mem_we high for exactly 256 cycles, addresses 0..255, data 0.
  - busy=1 and cpu_rst_n=0 throughout; load_ready rises on cycle 257.
- Program load: stream words (3,16'h2000), (4,16'h0008), (5,16'h2001), (6,16'h000B), (7,16'h0000), (8,16'h7000, last), with load_valid gaps between words.
  - The memory holds exactly these values; words_loaded=6.
  - cpu_rst_n rises one cycle after word 8 is accepted; busy falls with it.
- Out-of-range: stream (300,16'h1234) followed by (9,16'hABCD, last).
  - No write occurs to address 300; err=1; word 9 written; words_loaded=1; RUN entered.
- Reboot: pulse reboot in RUN.
  - cpu_rst_n=0 at the next edge; err=0 and words_loaded=0.
  - The full 256-cycle flush repeats, then LOAD.
  - A reboot pulse during FLUSH has no effect.
- Async reset mid-load: assert rst while in LOAD after 2 accepted words.
  - All outputs return to reset values immediately without waiting for a clock edge.
  - After release, the flush restarts at address 0.
- FLUSH_EN=0: release reset.
  - load_ready=1 on the first cycle; no flush writes; single last word (0,16'h0001) -> RUN.
